// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port count, flit format, port indices
// and the output-arbiter state encoding.
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int FLIT_W    = 16;
  localparam int TAIL_BIT  = FLIT_W - 1;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/output_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first requester found at or
// after (last_i + 1) mod N, returned as a one-hot vector plus a valid flag.
module rr_pick #(
  parameter int N    = 5,
  parameter int IDXW = 3
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [N-1:0]    grant_o,
  output logic            valid_o
);

  // Walk the ring starting just past the previous winner; first hit wins.
  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(last_i) + 1 + k) % N;
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Output-port arbiter for the NoC router. Wormhole-style: an input wins the
// output in IDLE (one arbitration cycle), then owns it until its tail flit
// is written. Ownership survives bubbles and downstream backpressure.
// Optional feature macro: OUTPUT_ARBITER_PERF_EN adds flit/packet counters.
module output_arbiter #(
  parameter int NUM_IN = noc_pkg::NUM_PORTS,
  parameter int FLIT_W = noc_pkg::FLIT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req_valid_i,
  input  logic [NUM_IN*FLIT_W-1:0] req_data_i,
  output logic [NUM_IN-1:0]        shift_o,
  input  logic                     full_i,
  output logic [FLIT_W-1:0]        data_o,
  output logic                     write_en_o,
  output logic [NUM_IN-1:0]        grant_o
`ifdef OUTPUT_ARBITER_PERF_EN
  ,
  output logic [31:0]              flit_cnt_o,
  output logic [31:0]              pkt_cnt_o
`endif
);

  import noc_pkg::*;

  localparam int IDXW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  arb_state_e        state_q, state_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   lastGrant_q, lastGrant_d;

  logic [NUM_IN-1:0] pickGrant;
  logic              pickValid;
  logic [IDXW-1:0]   pickIdx;

  logic              ownerValid;
  logic [FLIT_W-1:0] ownerFlit;
  logic              fire;
  logic              tailFire;

  rr_pick #(
    .N    (NUM_IN),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .last_i  (lastGrant_q),
    .grant_o (pickGrant),
    .valid_o (pickValid)
  );

  // Convert the picker's one-hot grant into the owner index we register.
  always_comb begin
    pickIdx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (pickGrant[i]) begin
        pickIdx = pickIdx | IDXW'(i);
      end
    end
  end

  // Select the owner's head flit and valid flag, and decide whether it fires.
  always_comb begin
    ownerValid = 1'b0;
    ownerFlit  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (owner_q == IDXW'(i)) begin
        ownerValid = req_valid_i[i];
        ownerFlit  = req_data_i[i*FLIT_W +: FLIT_W];
      end
    end
    fire     = (state_q == BUSY) && ownerValid && !full_i && !rst;
    tailFire = fire && ownerFlit[FLIT_W-1];
  end

  // Next-state and output logic; outputs are silenced while reset is held.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    grant_o     = '0;
    shift_o     = '0;
    write_en_o  = 1'b0;
    data_o      = '0;

    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          owner_d = pickIdx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (owner_q == IDXW'(i) && !rst) begin
            grant_o[i] = 1'b1;
            shift_o[i] = fire;
          end
        end
        if (fire) begin
          write_en_o = 1'b1;
          data_o     = ownerFlit;
        end
        if (tailFire) begin
          state_d     = IDLE;
          lastGrant_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset points last grant at the final port so port 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      lastGrant_q <= IDXW'(NUM_IN - 1);
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
    end
  end

`ifdef OUTPUT_ARBITER_PERF_EN
  logic [31:0] flitCnt_q, flitCnt_d;
  logic [31:0] pktCnt_q, pktCnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    flitCnt_d = flitCnt_q + (fire ? 32'd1 : 32'd0);
    pktCnt_d  = pktCnt_q + (tailFire ? 32'd1 : 32'd0);
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      flitCnt_q <= '0;
      pktCnt_q  <= '0;
    end else begin
      flitCnt_q <= flitCnt_d;
      pktCnt_q  <= pktCnt_d;
    end
  end

  assign flit_cnt_o = flitCnt_q;
  assign pkt_cnt_o  = pktCnt_q;
`endif

endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter NUM_IN, default 5, number of input ports sharing this output (N,S,E,W,Local).
REQ-002 Parameter FLIT_W, default 16, flit width in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  NUM_IN  per-input "FIFO non-empty" flag.
REQ-006 req_data_i  input  NUM_IN x FLIT_W  per-input FIFO head flit, show-ahead.
REQ-007 shift_o  output  NUM_IN  one-hot pop to the granted input FIFO.
REQ-008 full_i  input  1  downstream buffer full; no write may be issued while high.
REQ-009 data_o  output  FLIT_W  flit to downstream.
REQ-010 write_en_o  output  1  downstream push strobe.
REQ-011 grant_o  output  NUM_IN  one-hot current owner; zero when idle.

Function
REQ-012 Flit bit FLIT_W-1 SHALL be the tail bit; a single-flit packet has tail set on its only flit.
REQ-013 FSM states SHALL be IDLE and BUSY; the owner index SHALL be held in a register while in BUSY.
REQ-014 In IDLE, if any req_valid_i is set, the block SHALL select the first requester at or after (last_grant+1) mod NUM_IN, register it as owner and enter BUSY the next cycle.
REQ-015 In IDLE, no shift_o or write_en_o SHALL assert; arbitration adds exactly one cycle before the first flit of each packet.
REQ-016 In BUSY, fire = req_valid_i[owner] & !full_i; on fire, shift_o[owner], write_en_o and data_o = req_data_i[owner] SHALL assert in the same cycle (combinational).
REQ-017 In BUSY, the block SHALL hold ownership across bubbles (owner invalid) and backpressure (full_i high) with no timeout.
REQ-018 A fire whose flit has tail set SHALL return the FSM to IDLE and load last_grant with owner.
REQ-019 Non-owner inputs SHALL never see shift_o, including when they request while the owner is stalled.
REQ-020 At most one shift_o bit SHALL be high in any cycle; shift_o SHALL never assert while the owner's req_valid_i is low.
REQ-021 When write_en_o is low, data_o SHALL be zero.

Reset
REQ-022 While rst is high at a clock edge: FSM to IDLE, owner cleared, last_grant = NUM_IN-1 (port 0 wins first), grant_o, shift_o and write_en_o all zero.
REQ-023 Reset mid-packet SHALL abandon the packet with no further shift_o; remaining flits are the upstream's concern.

Configuration
REQ-024 Macro OUTPUT_ARBITER_PERF_EN, when defined, SHALL add 32-bit outputs flit_cnt_o (increments on every fire) and pkt_cnt_o (increments on every tail fire), wrap at 2^32, cleared by rst.
REQ-025 Without OUTPUT_ARBITER_PERF_EN these ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-026 Package noc_pkg SHALL hold NUM_PORTS, FLIT_W, TAIL_BIT, the port-index enum (NORTH, SOUTH, EAST, WEST, LOCAL) and the arbiter state enum.
REQ-027 Round-robin selection SHALL live in sub-module rr_pick (request vector plus last index in; one-hot grant plus valid out), purely combinational.

Verification
REQ-028 Reset, then only input 2 valid with 3-flit packet 0x0001, 0x0002, 0x8003 and full_i=0 -> grant_o=00100 after 1 cycle; writes on 3 consecutive cycles with those values; then IDLE.
REQ-029 All 5 inputs continuously hold single-flit packets (tail set) -> grants in order 0,1,2,3,4,0, one flit every 2 cycles.
REQ-030 Input 1 owns mid-packet; full_i high for 4 cycles while input 3 requests -> no write_en_o, no shift_o[3]; resumes on input 1 when full_i drops.
REQ-031 Owner req_valid_i drops for 2 cycles mid-packet -> grant_o held, no write; packet completes after valid returns.
REQ-032 rst asserted on the 2nd flit of a 4-flit packet -> next cycle grant_o=0, shift_o=0, write_en_o=0; next arbitration starts at port 0.
REQ-033 With OUTPUT_ARBITER_PERF_EN, send 3 packets of lengths 1, 2 and 4 -> flit_cnt_o=7, pkt_cnt_o=3.
